// File: rtl/mult_32_bit_seq.sv
// mult_32_bit_seq
//   Sequential 32x32 shift-add multiplier producing a 64-bit product into
//   hi/lo result registers, one partial product per clock (32 iterations).
//   A start/busy/done handshake lets the control unit stall while the
//   product is formed. hi/lo change only on a completion edge or on reset.
//
//   Optional feature macro: SIGNED_MULT_EN
//     defined   -> `sign` input exists; sign=1 multiplies two's-complement
//                  operands (magnitudes on accept, negate on completion).
//     undefined -> no `sign` port, unsigned only, no negation logic.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request, accepted in IDLE or DONE
//   a      in  32   multiplicand, sampled on the accept edge
//   b      in  32   multiplier, sampled on the accept edge
//   sign   in   1   (SIGNED_MULT_EN only) two's-complement operands
//   busy   out  1   high while iterating
//   done   out  1   one-cycle pulse when hi/lo take a new result
//   hi     out 32   product[63:32]
//   lo     out 32   product[31:0]
module mult_32_bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef SIGNED_MULT_EN
  input  logic        sign,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;

  logic        accept;
  logic [32:0] sum;
  logic [31:0] acc_d;
  logic [31:0] mplier_d;
  logic [63:0] prod_d;
  logic [31:0] mcand_d;
  logic [31:0] mplier_init_d;

`ifdef SIGNED_MULT_EN
  logic neg_q;
  logic neg_d;
`endif

  assign accept = start && (state_q != BUSY);

  // Operand capture: in the signed build, negative operands are converted
  // to magnitudes so the iteration datapath stays purely unsigned.
  always_comb begin
`ifdef SIGNED_MULT_EN
    mcand_d       = (sign && a[31]) ? (~a + 32'd1) : a;
    mplier_init_d = (sign && b[31]) ? (~b + 32'd1) : b;
    neg_d         = sign && (a[31] ^ b[31]);
`else
    mcand_d       = a;
    mplier_init_d = b;
`endif
  end

  // One shift-add step. The multiplier register doubles as the low half of
  // the product: {carry, acc, mplier} shifts right as a single 65-bit value.
  // prod_d is the full product as it stands after this step, so the 32nd
  // step's result can be loaded into hi/lo on that same edge.
  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
    acc_d    = sum[32:1];
    mplier_d = {sum[0], mplier_q[31:1]};
    prod_d   = {acc_d, mplier_d};
`ifdef SIGNED_MULT_EN
    if (neg_q) begin
      prod_d = ~{acc_d, mplier_d} + 64'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef SIGNED_MULT_EN
      neg_q    <= 1'b0;
`endif
    end else if (accept) begin
      state_q  <= BUSY;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_init_d;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef SIGNED_MULT_EN
      neg_q    <= neg_d;
`endif
    end else begin
      case (state_q)
        BUSY: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= prod_d[63:32];
            lo_q    <= prod_d[31:0];
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_32_bit_seq.sv
// Testbench for mult_32_bit_seq: table-driven vectors, hand-written
// multi-cycle sequences, and random operands against an arithmetic model.
module tb_mult_32_bit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sign;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_cmp;
  int unsigned n_fail;
  logic [63:0] prev;

  mult_32_bit_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SIGNED_MULT_EN
    .sign  (sign),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint sx;
    longint sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'h0, x} * {32'h0, y};
  endfunction

  // Full transaction with timing checks; starts and ends on a negedge.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic ts,
                        input logic [63:0] exp, input string nm);
    int n;
    @(negedge clk);
    a = ta; b = tb2; sign = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; sign = 1'($urandom);
    chk({nm, " hold_in_busy"}, {hi, lo}, prev);
    n = 0;
    while (busy && !done && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 64'(n), 64'd32);
    chk({nm, " done_busy"}, {62'd0, done, busy}, 64'd2);
    chk({nm, " product"}, {hi, lo}, exp);
    prev = exp;
    @(negedge clk);
    chk({nm, " done_drop"}, {62'd0, done, busy}, 64'd0);
    chk({nm, " hold_after"}, {hi, lo}, prev);
  endtask

  vec_t vecs[$];

  initial begin
    int dones;
    int busy_low;
    int overlap;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    n_cmp = 0; n_fail = 0; prev = '0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sign = 1'b0;

    vecs.push_back('{32'd3,         32'd5,         1'b0, 64'h0000_0000_0000_000F});
    vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'd0,         32'h12345678,  1'b0, 64'h0});
    vecs.push_back('{32'd2,         32'd7,         1'b0, 64'h0000_0000_0000_000E});
    vecs.push_back('{32'h00010000,  32'h00010000,  1'b0, 64'h0000_0001_0000_0000});
    vecs.push_back('{32'h80000000,  32'd2,         1'b0, 64'h0000_0001_0000_0000});
    vecs.push_back('{32'hFFFFFFFF,  32'd1,         1'b0, 64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{32'hFFFFFFFE,  32'd3,         1'b0, 64'h0000_0002_FFFF_FFFA});
`ifdef SIGNED_MULT_EN
    vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 64'h0000_0000_0000_0001});
    vecs.push_back('{32'hFFFFFFFE,  32'd3,         1'b1, 64'hFFFF_FFFF_FFFF_FFFA});
    vecs.push_back('{32'h80000000,  32'h80000000,  1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'h80000000,  32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{32'd0,         32'hFFFFFFF0,  1'b1, 64'h0});
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {busy, done, hi, lo}, 66'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // start re-pulsed during BUSY with different operands is ignored
    @(negedge clk);
    a = 32'h00001234; b = 32'h00000010; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 34; c++) begin
      if (c == 5 || c == 20) begin
        a = 32'hDEADBEEF; b = 32'h0BADF00D; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        chk("ignore_start product", {hi, lo}, 64'h0000_0000_0001_2340);
      end
      @(negedge clk);
    end
    chk("ignore_start done_count", 64'(dones), 64'd1);
    prev = 64'h0000_0000_0001_2340;

    // reset in BUSY cycle 10 aborts and clears results
    @(negedge clk);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset outputs", {busy, done, hi, lo}, 66'd0);
    repeat (40) @(negedge clk);
    chk("midreset idle", {busy, done, hi, lo}, 66'd0);
    prev = '0;
    run_op(32'd11, 32'd13, 1'b0, 64'd143, "after_reset");

    // start together with rst: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'd4; b = 32'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", {busy, done, hi, lo}, 66'd0);
    prev = '0;

    // start held high: one product every 33 cycles, busy low only in done
    @(negedge clk);
    a = 32'd2; b = 32'd7; sign = 1'b0; start = 1'b1;
    dones = 0; busy_low = 0; overlap = 0;
    for (int c = 1; c <= 99; c++) begin
      @(negedge clk);
      if (busy && done) overlap++;
      if (!busy) busy_low++;
      if (done) begin
        dones++;
        chk("held_start product", {hi, lo}, 64'h0000_0000_0000_000E);
        chk("held_start spacing", 64'(c), 64'(33 * dones));
      end
    end
    start = 1'b0;
    chk("held_start done_count", 64'(dones), 64'd3);
    chk("held_start busy_low", 64'(busy_low), 64'd3);
    chk("held_start overlap", 64'(overlap), 64'd0);
    @(negedge clk);
    prev = 64'h0000_0000_0000_000E;

    // random operands against the arithmetic model
    for (int r = 0; r < 20; r++) begin
      ra = $urandom;
      rb = $urandom;
      if (r % 4 == 0) ra = ra >> $urandom_range(31, 0);
`ifdef SIGNED_MULT_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_32_bit_seq.md
# mult_32_bit_seq

Sequential 32-bit shift-add multiplier that consumes the 32-bit operand selected by the datapath's 2:1 operand mux (ALU B-operand path) together with the A operand. It produces a 64-bit product into hi/lo result registers. A start/busy/done handshake lets the control unit stall while the product is formed at one partial product per clock. Results are held stable for HI/LO move instructions.

## Interface
Parameters:
- none (width fixed at 32; iteration count fixed at 32)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; accepted only when block is not busy
- a  input  32  multiplicand, sampled on the accept edge
- b  input  32  multiplier (from operand mux output), sampled on the accept edge
- sign  input  1  present only with SIGNED_MULT_EN; 1 = two's-complement operands, sampled on the accept edge
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when hi/lo take a new result
- hi  output  32  product[63:32]
- lo  output  32  product[31:0]

## Operation
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; internal accumulator, operand and counter registers cleared.
- Accept: start=1 in IDLE or DONE. On that edge: a/b (and sign) are captured, counter=0, accumulator=0, state→BUSY. Start in BUSY is ignored with no side effect.
- BUSY iteration, once per edge: if multiplier LSB=1, add the multiplicand to the upper half of a 65-bit accumulator {carry, acc_hi}. Then shift {carry, acc_hi, multiplier} right by 1, and increment the counter.
- After the 32nd iteration edge: hi/lo ← final 64-bit product; state→DONE; busy→0; done→1.
- DONE lasts exactly one cycle, then state→IDLE (done→0), unless start=1 in that cycle, which starts a new accept instead.
- hi/lo hold the last result through IDLE and through a subsequent BUSY. They change only on a completion edge or on reset.
- Arithmetic: unsigned operands give the exact 64-bit product; no overflow flag is produced.
- Reset mid-operation (any state) aborts immediately to reset values; the partial result is discarded.
- Operand input changes after the accept edge have no effect.

## Timing
- Accept at edge k: busy=1 from edge k through edge k+32 (32 cycles high).
- Completion edge k+32: hi/lo updated; done=1 for the cycle between edges k+32 and k+33.
- Latency from start sample to result visible: 32 cycles.
- Back-to-back: start asserted during the done cycle is accepted at edge k+33; busy is high again after that edge. Throughput is one product per 33 cycles.
- start asserted together with rst: rst wins; no accept.
- busy and done are never high simultaneously.

## Configuration
- SIGNED_MULT_EN:
  - Defined: the `sign` port exists. When sign=1 at accept, operands are converted to magnitudes on the accept edge, and result sign = a[31]^b[31]. On the completion edge the 64-bit magnitude is two's-complement negated when the result sign is 1. Latency is unchanged. With sign=0, behaviour is identical to the unsigned build.
  - Undefined: no `sign` port; all operands are unsigned; no negation logic is built.

## Test plan
- Reset, then a=3, b=5, start pulse → busy high 32 cycles, done pulse on cycle 33, hi=0x00000000, lo=0x0000000F; done low the next cycle and hi/lo held.
- a=0xFFFFFFFF, b=0xFFFFFFFF unsigned → hi=0xFFFFFFFE, lo=0x00000001; a=0, b=0x12345678 → hi=lo=0.
- start re-pulsed with different operands at cycles 5 and 20 of BUSY → ignored; result is that of the original operands; done pulses exactly once.
- rst asserted at BUSY cycle 10 → next cycle busy=0, done=0, hi=lo=0, state IDLE. A fresh start then completes normally at 32 cycles.
- start held high continuously with a=2, b=7 → done pulses every 33 cycles, lo=0x0000000E each time, busy low only during each done cycle.
- With SIGNED_MULT_EN and sign=1: a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1; a=0xFFFFFFFE, b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA. With sign=0 on the same operands, results match the unsigned build.
